xrv1_fetch_buf: RTL
===================

# xrv1_fetch_buf

Parametrised instruction fetch buffer sitting between the instruction memory port and the decoder of the xrv1 core. It replaces the fixed 3-entry queue with a configurable-depth circular buffer of 32-bit fetch words. It has ready/valid handshakes on both sides, a flush, and error propagation. It also supports optional 16-bit parcel alignment, which delivers compressed and word-straddling 32-bit instructions one per handshake.

## Interface
- `DEPTH_P`, 4: number of 32-bit fetch-word entries, ≥2, not required to be a power of two.
- `AF_THRESH_P`, `DEPTH_P-1`: `almost_full_o` asserts when count ≥ this value, 1..`DEPTH_P`.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: discard all contents; sampled each cycle.
- `enq_vld_i` in 1: fetch word offered.
- `enq_rdy_o` out 1: buffer can accept a word.
- `enq_data_i` in 32: fetch word.
- `enq_pc_i` in 32: PC of the fetched word; bit 1 is significant only on the first enqueue after a flush or reset.
- `enq_err_i` in 1: bus/access error for this word.
- `deq_vld_o` out 1: complete instruction available at the head.
- `deq_rdy_i` in 1: decoder consumes the head instruction.
- `deq_insn_o` out 32: instruction, zero-extended when compressed.
- `deq_pc_o` out 32: PC of the instruction.
- `deq_rvc_o` out 1: instruction is 16-bit.
- `deq_err_o` out 1: instruction carries a fetch error.
- `count_o` out `$clog2(DEPTH_P+1)`: valid entries.
- `empty_o`, `full_o`, `almost_full_o` out 1: occupancy flags.

## Operation
- **Storage:** each entry is {data[31:0], pc[31:2], err}.
  - Write pointer and read pointer wrap at `DEPTH_P` to 0.
  - A half-word select `hsel` marks whether the head instruction starts in the low parcel (0) or the high parcel (1).
- **Head parcel decoding:** the head parcel P is `data[15:0]` when `hsel`=0 and `data[31:16]` when `hsel`=1. An instruction is compressed when P[1:0] ≠ 2'b11.
- **`hsel`=0:**
  - Compressed: `deq_insn_o`={16'b0,P}.
  - 32-bit: `deq_insn_o`=`data`.
- **`hsel`=1:**
  - Compressed: `deq_insn_o`={16'b0,P}.
  - 32-bit (straddle): `deq_insn_o`={next.data[15:0], P}. Valid only when count ≥2.
- **Validity and outputs:**
  - `deq_vld_o` = count ≥1 and (not straddle, or count ≥2, or head.err).
  - `deq_pc_o` = {head.pc, `hsel`, 1'b0}.
  - `deq_err_o` = head.err | (straddle & count≥2 & next.err).
  - A head with err is treated as 32-bit (`deq_rvc_o`=0).
- **On a dequeue handshake** (`deq_vld_o` & `deq_rdy_i`):
  - Compressed, `hsel`=0: `hsel`←1, no pop.
  - Compressed, `hsel`=1: pop, `hsel`←0.
  - 32-bit, `hsel`=0: pop, `hsel` stays 0.
  - Straddle: pop one entry, `hsel` stays 1.
  - Erroring head: pop, `hsel`←0.
- **Enqueue handshake:** `enq_vld_i` & `enq_rdy_o` writes the word at the write pointer.
  - `enq_rdy_o` = count < `DEPTH_P`, registered-count based with no combinational path from `deq_rdy_i`.
  - An enqueue and a pop in the same cycle leave count unchanged.
- **Alignment after flush/reset:** reset or flush sets the internal `align_pend` flag. The first accepted enqueue then loads `hsel`←`enq_pc_i[1]` and clears `align_pend`.
- **Flush:** `flush_i` has priority over enqueue and dequeue in the same cycle.
  - Next cycle: count=0, both pointers 0, `hsel`=0, `align_pend`=1.
  - A word offered in the flush cycle is dropped.
- **Flags:** `empty_o`=(count==0), `full_o`=(count==`DEPTH_P`), `almost_full_o`=(count≥`AF_THRESH_P`).

## Timing
- Reset values (asynchronous, take effect immediately on `rst_ni` low):
  - Outputs: `enq_rdy_o`=1, `deq_vld_o`=0, `deq_insn_o`=0, `deq_pc_o`=0, `deq_rvc_o`=0, `deq_err_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=0.
  - Internal state: storage cleared to 0.
- Latency: a word enqueued in cycle N is visible on `deq_*` in cycle N+1. There is no bypass from enqueue to dequeue.
- All `deq_*` outputs and flags are combinational from registered state only.
- `enq_rdy_o` does not depend on `enq_vld_i` or `deq_rdy_i`.
- Reset mid-operation discards all contents and `align_pend` becomes 1.

## Configuration
- `XRV1_IFQ_RVC_EN` defined: parcel alignment, compressed detection and straddling are built as described above.
- Undefined:
  - Every instruction is 32-bit and `hsel` is tied to 0.
  - `enq_pc_i[1]` is ignored and `deq_rvc_o` is tied to 0.
  - Every dequeue handshake pops one entry.
  - `deq_vld_o` = count ≥1.

## Structure
- Package `xrv1_ifq_pkg`:
  - `ifq_entry_t` struct {data, pc[31:2], err}.
  - Function `is_rvc(logic [15:0])`.
  - Localparam `ILEN`=32.
- Sub-module `xrv1_parcel_aligner`: combinational block that takes head/next entries, `hsel` and count. It produces `deq_insn_o`, `deq_rvc_o`, `deq_err_o`, `deq_vld_o` and the pop/`hsel`-next decision.

## Test plan
- **Fill/drain:** with `DEPTH_P`=4, enqueue words at PCs 0x0,0x4,0x8,0xC with `deq_rdy_i`=0.
  - Expect `full_o`=1, `enq_rdy_o`=0 and `almost_full_o`=1 at count 3.
  - Then drain in order, with `deq_pc_o` 0x0..0xC and `empty_o`=1 at the end.
- **Compressed pair:** enqueue 0x00014501 at PC 0x100.
  - First dequeue gives `deq_insn_o`=0x4501, PC 0x100, `deq_rvc_o`=1.
  - Second gives 0x0001, PC 0x102.
  - Then count=0.
- **Straddle:** after flush, enqueue 0x00B34501 at PC 0x200, then 0x12340033 at PC 0x204.
  - Dequeue 0x4501 at PC 0x200.
  - Dequeue the straddled 0x003300B3 at PC 0x202, with `deq_vld_o`=0 until the second word arrives.
- **Unaligned target:** flush, then enqueue 0x4501FFFF with `enq_pc_i`=0x302. The first dequeue gives PC 0x302 and `deq_insn_o`=0x4501.
- **Flush priority:** full buffer, assert `flush_i` with `enq_vld_i`=1 and `deq_rdy_i`=1. Next cycle count=0 and `deq_vld_o`=0.
- **Error and wrap:** enqueue with `enq_err_i`=1 on the 6th word of `DEPTH_P`=4 continuous streaming.
  - `deq_err_o`=1 only on that instruction.
  - Pointer wrap keeps PCs in order.

Source files
------------

// File: rtl/xrv1_ifq_pkg.sv
// Shared types and helpers for the xrv1 instruction fetch buffer.
package xrv1_ifq_pkg;

  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [ILEN-1:0] data;
    logic [31:2]     pc;
    logic            err;
  } ifq_entry_t;

  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/xrv1_parcel_aligner.sv
// Combinational head decoder: builds the head instruction from head/next entries and decides
// whether a dequeue pops an entry. Parcel alignment is built only with XRV1_IFQ_RVC_EN.
module xrv1_parcel_aligner
  import xrv1_ifq_pkg::*;
#(
  parameter int unsigned CntW = 3
) (
  input  ifq_entry_t       head_i,
  input  ifq_entry_t       next_i,
  input  logic             hsel_i,
  input  logic [CntW-1:0]  count_i,
  output logic [ILEN-1:0]  insn_o,
  output logic [31:0]      pc_o,
  output logic             rvc_o,
  output logic             err_o,
  output logic             vld_o,
  output logic             pop_o,
  output logic             hsel_nxt_o
);

`ifdef XRV1_IFQ_RVC_EN
  logic        cnt_ge1;
  logic        cnt_ge2;
  logic [15:0] parcel;
  logic        rvc;
  logic        straddle;

  assign cnt_ge1 = (count_i != '0);
  assign cnt_ge2 = (count_i > CntW'(1));

  always_comb begin
    parcel   = hsel_i ? head_i.data[31:16] : head_i.data[15:0];
    // An erroring head is forced to look like a 32-bit instruction.
    rvc      = is_rvc(parcel) & ~head_i.err;
    straddle = hsel_i & ~rvc & ~head_i.err;

    if (rvc) begin
      insn_o = {16'b0, parcel};
    end else if (straddle) begin
      insn_o = {next_i.data[15:0], parcel};
    end else begin
      insn_o = head_i.data;
    end

    pc_o  = {head_i.pc, hsel_i, 1'b0};
    rvc_o = rvc & cnt_ge1;
    err_o = head_i.err | (straddle & cnt_ge2 & next_i.err);
    vld_o = cnt_ge1 & (~straddle | cnt_ge2);

    pop_o      = 1'b1;
    hsel_nxt_o = 1'b0;
    if (rvc) begin
      pop_o      = hsel_i;
      hsel_nxt_o = ~hsel_i;
    end else if (straddle) begin
      hsel_nxt_o = 1'b1;
    end
  end
`else
  logic unused_in;

  assign unused_in  = ^{next_i, hsel_i};
  assign insn_o     = head_i.data;
  assign pc_o       = {head_i.pc, 2'b00};
  assign rvc_o      = 1'b0;
  assign err_o      = head_i.err;
  assign vld_o      = (count_i != '0);
  assign pop_o      = 1'b1;
  assign hsel_nxt_o = 1'b0;
`endif

endmodule

// File: rtl/xrv1_fetch_buf.sv
// Configurable-depth circular fetch buffer between imem and decode of the xrv1 core.
// Define XRV1_IFQ_RVC_EN to build 16-bit parcel alignment (compressed and straddling insns).
module xrv1_fetch_buf
  import xrv1_ifq_pkg::*;
#(
  parameter int unsigned DEPTH_P     = 4,
  parameter int unsigned AF_THRESH_P = DEPTH_P - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         enq_vld_i,
  output logic                         enq_rdy_o,
  input  logic [31:0]                  enq_data_i,
  input  logic [31:0]                  enq_pc_i,
  input  logic                         enq_err_i,
  output logic                         deq_vld_o,
  input  logic                         deq_rdy_i,
  output logic [31:0]                  deq_insn_o,
  output logic [31:0]                  deq_pc_o,
  output logic                         deq_rvc_o,
  output logic                         deq_err_o,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         almost_full_o
);

  localparam int unsigned     CntW     = $clog2(DEPTH_P + 1);
  localparam int unsigned     PtrW     = $clog2(DEPTH_P);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH_P);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_THRESH_P);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH_P - 1);

  ifq_entry_t      mem_q [DEPTH_P];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] rptr_nxt;
  logic [CntW-1:0] count_q, count_d;
  logic            hsel_q, hsel_d;
  logic            align_pend_q, align_pend_d;
  logic            enq_fire;
  logic            deq_fire;
  logic            pop;
  logic            al_pop;
  logic            al_hsel_nxt;

`ifdef XRV1_IFQ_RVC_EN
  logic unused_pc;
  assign unused_pc = enq_pc_i[0];
`else
  logic unused_pc;
  assign unused_pc = ^{enq_pc_i[1:0], align_pend_q};
`endif

  // Ready looks only at registered occupancy, never at deq_rdy_i.
  assign enq_rdy_o = (count_q != DepthCnt);
  assign enq_fire  = enq_vld_i & enq_rdy_o & ~flush_i;
  assign rptr_nxt  = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);

  xrv1_parcel_aligner #(
    .CntW (CntW)
  ) u_aligner (
    .head_i     (mem_q[rptr_q]),
    .next_i     (mem_q[rptr_nxt]),
    .hsel_i     (hsel_q),
    .count_i    (count_q),
    .insn_o     (deq_insn_o),
    .pc_o       (deq_pc_o),
    .rvc_o      (deq_rvc_o),
    .err_o      (deq_err_o),
    .vld_o      (deq_vld_o),
    .pop_o      (al_pop),
    .hsel_nxt_o (al_hsel_nxt)
  );

  assign deq_fire = deq_vld_o & deq_rdy_i & ~flush_i;
  assign pop      = deq_fire & al_pop;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    hsel_d       = hsel_q;
    align_pend_d = align_pend_q;

    if (flush_i) begin
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
      hsel_d       = 1'b0;
      align_pend_d = 1'b1;
    end else begin
      if (enq_fire) begin
        wptr_d       = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        align_pend_d = 1'b0;
`ifdef XRV1_IFQ_RVC_EN
        // Buffer is empty while alignment is pending, so no dequeue can collide here.
        if (align_pend_q) begin
          hsel_d = enq_pc_i[1];
        end
`endif
      end
      if (deq_fire) begin
        hsel_d = al_hsel_nxt;
      end
      if (pop) begin
        rptr_d = rptr_nxt;
      end
      case ({enq_fire, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      hsel_q       <= 1'b0;
      align_pend_q <= 1'b1;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      hsel_q       <= hsel_d;
      align_pend_q <= align_pend_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH_P); i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_fire) begin
      mem_q[wptr_q] <= '{data: enq_data_i, pc: enq_pc_i[31:2], err: enq_err_i};
    end
  end

  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == DepthCnt);
  assign almost_full_o = (count_q >= AfCnt);

endmodule
